// File: rtl/pa_clic_arb_seq.sv
// Sequential CLIC arbiter: scans GROUP kid slots per cycle, accumulates the best
// qualifying interrupt over a pass, presents it to the core and claims it on ack.
//
// state | meaning
// SCAN  | continuous group scan, output refreshed at the end of each pass
// CLAIM | one-cycle claim pulse to the winning kid, scan held at group 0

module pa_clic_arb_seq #(
    parameter int NUM_KIDS = 64,
    parameter int GROUP    = 4,
    parameter int CTLBITS  = 3,
    parameter int ID_W     = 6
) (
    input  logic                             forever_cpuclk,
    input  logic                             cpurst,
    input  logic [NUM_KIDS-1:0]              kid_arb_int_req,
    input  logic [NUM_KIDS*(CTLBITS+1)-1:0]  kid_arb_int_all,
    input  logic [NUM_KIDS-1:0]              kid_arb_int_hv,
    input  logic [CTLBITS:0]                 cpu_clic_mintresh,
    input  logic                             busif_arb_cfg_chg,
    input  logic                             cpu_clic_int_ack,
    output logic                             arb_cpu_int_vld,
    output logic [ID_W-1:0]                  arb_cpu_int_id,
    output logic [CTLBITS:0]                 arb_cpu_int_key,
    output logic                             arb_cpu_int_hv,
    output logic                             arb_kid_claim_vld,
    output logic [ID_W-1:0]                  arb_kid_claim_id
);

    localparam int KEY_W = CTLBITS + 1;
    localparam int P     = NUM_KIDS / GROUP;
    localparam int CNT_W = (P > 1) ? $clog2(P) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(P - 1);

    typedef enum logic {
        SCAN  = 1'b0,
        CLAIM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   grp_cnt_q, grp_cnt_d;
    logic               best_vld_q, best_vld_d;
    logic [ID_W-1:0]    best_id_q, best_id_d;
    logic [KEY_W-1:0]   best_key_q, best_key_d;
    logic               best_hv_q, best_hv_d;
    logic               out_vld_q, out_vld_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic [KEY_W-1:0]   out_key_q, out_key_d;
    logic               out_hv_q, out_hv_d;
    logic               claim_vld_q, claim_vld_d;
    logic [ID_W-1:0]    claim_id_q, claim_id_d;

    int                 idx;
    logic [KEY_W-1:0]   kid_key;
    logic               cand_vld;
    logic [ID_W-1:0]    cand_id;
    logic [KEY_W-1:0]   cand_key;
    logic               cand_hv;
    logic               take_cand;
    logic               m_vld;
    logic [ID_W-1:0]    m_id;
    logic [KEY_W-1:0]   m_key;
    logic               m_hv;

    // Ascending scan with strict compare keeps the lowest id on equal keys.
    always_comb begin
        idx      = 0;
        kid_key  = '0;
        cand_vld = 1'b0;
        cand_id  = '0;
        cand_key = '0;
        cand_hv  = 1'b0;
        for (int g = 0; g < GROUP; g++) begin
            idx     = int'(grp_cnt_q) * GROUP + g;
            kid_key = kid_arb_int_all[idx*KEY_W +: KEY_W];
            if (kid_arb_int_req[idx] && (kid_key > cpu_clic_mintresh) &&
                (!cand_vld || (kid_key > cand_key))) begin
                cand_vld = 1'b1;
                cand_id  = ID_W'(idx);
                cand_key = kid_key;
                cand_hv  = kid_arb_int_hv[idx];
            end
        end
    end

    always_comb begin
        take_cand = cand_vld && (!best_vld_q || (cand_key > best_key_q));
        m_vld     = best_vld_q | cand_vld;
        m_id      = take_cand ? cand_id  : best_id_q;
        m_key     = take_cand ? cand_key : best_key_q;
        m_hv      = take_cand ? cand_hv  : best_hv_q;
    end

    always_comb begin
        state_d     = state_q;
        grp_cnt_d   = grp_cnt_q;
        best_vld_d  = best_vld_q;
        best_id_d   = best_id_q;
        best_key_d  = best_key_q;
        best_hv_d   = best_hv_q;
        out_vld_d   = out_vld_q;
        out_id_d    = out_id_q;
        out_key_d   = out_key_q;
        out_hv_d    = out_hv_q;
        claim_vld_d = 1'b0;
        claim_id_d  = claim_id_q;

        case (state_q)
            SCAN: begin
                if (cpu_clic_int_ack && out_vld_q) begin
                    // Claim takes precedence over both config change and pass end.
                    state_d     = CLAIM;
                    claim_vld_d = 1'b1;
                    claim_id_d  = out_id_q;
                    out_vld_d   = 1'b0;
                    grp_cnt_d   = '0;
                    best_vld_d  = 1'b0;
                    best_id_d   = '0;
                    best_key_d  = '0;
                    best_hv_d   = 1'b0;
                end else if (busif_arb_cfg_chg) begin
                    out_vld_d  = 1'b0;
                    grp_cnt_d  = '0;
                    best_vld_d = 1'b0;
                    best_id_d  = '0;
                    best_key_d = '0;
                    best_hv_d  = 1'b0;
                end else if (grp_cnt_q == LAST_GRP) begin
                    out_vld_d  = m_vld;
                    out_id_d   = m_id;
                    out_key_d  = m_key;
                    out_hv_d   = m_hv;
                    grp_cnt_d  = '0;
                    best_vld_d = 1'b0;
                    best_id_d  = '0;
                    best_key_d = '0;
                    best_hv_d  = 1'b0;
                end else begin
                    best_vld_d = m_vld;
                    best_id_d  = m_id;
                    best_key_d = m_key;
                    best_hv_d  = m_hv;
                    grp_cnt_d  = grp_cnt_q + CNT_W'(1);
                end
            end
            CLAIM: begin
                state_d    = SCAN;
                out_vld_d  = 1'b0;
                grp_cnt_d  = '0;
                best_vld_d = 1'b0;
                best_id_d  = '0;
                best_key_d = '0;
                best_hv_d  = 1'b0;
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q     <= SCAN;
            grp_cnt_q   <= '0;
            best_vld_q  <= 1'b0;
            best_id_q   <= '0;
            best_key_q  <= '0;
            best_hv_q   <= 1'b0;
            out_vld_q   <= 1'b0;
            out_id_q    <= '0;
            out_key_q   <= '0;
            out_hv_q    <= 1'b0;
            claim_vld_q <= 1'b0;
            claim_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            grp_cnt_q   <= grp_cnt_d;
            best_vld_q  <= best_vld_d;
            best_id_q   <= best_id_d;
            best_key_q  <= best_key_d;
            best_hv_q   <= best_hv_d;
            out_vld_q   <= out_vld_d;
            out_id_q    <= out_id_d;
            out_key_q   <= out_key_d;
            out_hv_q    <= out_hv_d;
            claim_vld_q <= claim_vld_d;
            claim_id_q  <= claim_id_d;
        end
    end

    assign arb_cpu_int_vld   = out_vld_q;
    assign arb_cpu_int_id    = out_id_q;
    assign arb_cpu_int_key   = out_key_q;
    assign arb_cpu_int_hv    = out_hv_q;
    assign arb_kid_claim_vld = claim_vld_q;
    assign arb_kid_claim_id  = claim_id_q;

endmodule

// File: tb/tb_pa_clic_arb_seq.sv
// Directed bench for pa_clic_arb_seq: stimulus pushes expected winners and claims
// with their due cycle; a negedge monitor pops and compares on each DUT event.

module tb_pa_clic_arb_seq;

    localparam int NK = 64;
    localparam int KW = 4;
    localparam int IW = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic [NK-1:0]    req;
    logic [NK*KW-1:0] kall;
    logic [NK-1:0]    hv;
    logic [KW-1:0]    mint;
    logic             cfg;
    logic             ack;
    logic             vld;
    logic [IW-1:0]    id;
    logic [KW-1:0]    key;
    logic             ohv;
    logic             cvld;
    logic [IW-1:0]    cid;

    pa_clic_arb_seq #(.NUM_KIDS(NK), .GROUP(4), .CTLBITS(3), .ID_W(IW)) dut (
        .forever_cpuclk    (clk),
        .cpurst            (rst),
        .kid_arb_int_req   (req),
        .kid_arb_int_all   (kall),
        .kid_arb_int_hv    (hv),
        .cpu_clic_mintresh (mint),
        .busif_arb_cfg_chg (cfg),
        .cpu_clic_int_ack  (ack),
        .arb_cpu_int_vld   (vld),
        .arb_cpu_int_id    (id),
        .arb_cpu_int_key   (key),
        .arb_cpu_int_hv    (ohv),
        .arb_kid_claim_vld (cvld),
        .arb_kid_claim_id  (cid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [IW-1:0] id; logic [KW-1:0] key; logic hv; int due; } win_t;
    typedef struct { logic [IW-1:0] id; int due; } clm_t;
    typedef struct { string name; logic [31:0] act; logic [31:0] exp; } dir_t;

    win_t win_q[$];
    clm_t clm_q[$];
    dir_t dir_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic clear_kids();
        req  = '0;
        hv   = '0;
        kall = '0;
    endtask

    task automatic set_kid(input int k, input logic [KW-1:0] kk, input logic h);
        req[k]           = 1'b1;
        kall[k*KW +: KW] = kk;
        hv[k]            = h;
    endtask

    task automatic pulse_cfg(output int c);
        c   = cyc;
        cfg = 1'b1;
        @(negedge clk);
        cfg = 1'b0;
    endtask

    task automatic expect_win(input int wid, input int wkey, input logic whv, input int due);
        win_t w;
        w.id  = IW'(wid);
        w.key = KW'(wkey);
        w.hv  = whv;
        w.due = due;
        win_q.push_back(w);
    endtask

    task automatic expect_claim(input int wid, input int due);
        clm_t cl;
        cl.id  = IW'(wid);
        cl.due = due;
        clm_q.push_back(cl);
    endtask

    task automatic direct(input string name, input logic [31:0] act, input logic [31:0] exp);
        dir_t d;
        d.name = name;
        d.act  = act;
        d.exp  = exp;
        dir_q.push_back(d);
    endtask

    initial begin
        int c, a, b, bad;
        rst  = 1'b1;
        cfg  = 1'b0;
        ack  = 1'b0;
        mint = '0;
        req  = '1;
        hv   = '0;
        for (int k = 0; k < NK; k++) kall[k*KW +: KW] = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            direct("reset_outputs", 32'({vld, id, key, ohv, cvld, cid}), 32'd0);
        end
        rst = 1'b0;
        c = cyc;
        expect_win(0, 1, 1'b0, c + 16);
        wait_cyc(c + 16);

        clear_kids();
        set_kid(37, 4'd5, 1'b1);
        pulse_cfg(c);
        expect_win(37, 5, 1'b1, c + 17);
        wait_cyc(c + 17);
        bad = 0;
        repeat (16) begin
            @(negedge clk);
            if (vld !== 1'b1 || id !== 6'd37) bad++;
        end
        direct("single_stable", 32'(bad), 32'd0);

        clear_kids();
        set_kid(3, 4'd6, 1'b0);
        set_kid(9, 4'd6, 1'b0);
        set_kid(50, 4'd7, 1'b0);
        pulse_cfg(c);
        expect_win(50, 7, 1'b0, c + 17);
        wait_cyc(c + 17);
        req[50] = 1'b0;
        expect_win(3, 6, 1'b0, c + 33);
        wait_cyc(c + 33);

        clear_kids();
        set_kid(10, 4'd4, 1'b0);
        mint = 4'd4;
        pulse_cfg(c);
        bad = 0;
        for (int k = c + 1; k <= c + 33; k++) begin
            wait_cyc(k);
            if (vld !== 1'b0) bad++;
        end
        direct("thresh_equal_no_vld", 32'(bad), 32'd0);
        mint = 4'd3;
        expect_win(10, 4, 1'b0, c + 49);
        wait_cyc(c + 49);

        clear_kids();
        mint = 4'd0;
        set_kid(37, 4'd5, 1'b1);
        pulse_cfg(c);
        expect_win(37, 5, 1'b1, c + 17);
        wait_cyc(c + 19);
        a   = cyc;
        ack = 1'b1;
        expect_claim(37, a + 1);
        bad = 0;
        for (int k = a + 1; k <= a + 17; k++) begin
            wait_cyc(k);
            ack = (k == a + 4);
            if (vld !== 1'b0) bad++;
        end
        ack = 1'b0;
        direct("claim_vld_low", 32'(bad), 32'd0);
        expect_win(37, 5, 1'b1, a + 18);
        wait_cyc(a + 20);

        b   = cyc;
        ack = 1'b1;
        cfg = 1'b1;
        expect_claim(37, b + 1);
        bad = 0;
        for (int k = b + 1; k <= b + 17; k++) begin
            wait_cyc(k);
            ack = 1'b0;
            cfg = 1'b0;
            if (vld !== 1'b0) bad++;
        end
        direct("cfg_ack_vld_low", 32'(bad), 32'd0);
        expect_win(37, 5, 1'b1, b + 18);
        wait_cyc(b + 18);

        req[37] = 1'b0;
        set_kid(40, 4'd6, 1'b0);
        wait_cyc(b + 33);
        ack = 1'b1;
        expect_claim(37, b + 34);
        @(negedge clk);
        ack = 1'b0;
        expect_win(40, 6, 1'b0, b + 51);
        wait_cyc(b + 54);
        done = 1'b1;
    end

    logic          pv = 1'b0;
    logic [IW-1:0] pid = '0;
    logic [KW-1:0] pkey = '0;
    logic          phv = 1'b0;

    always @(negedge clk) begin
        win_t w;
        clm_t cl;
        dir_t d;
        while (dir_q.size() > 0) begin
            d = dir_q.pop_front();
            checks++;
            if (d.act !== d.exp) begin
                failures++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", d.name, d.act, d.exp, cyc);
            end
        end
        if (!rst) begin
            if (win_q.size() > 0 && cyc > win_q[0].due) begin
                w = win_q.pop_front();
                checks++;
                failures++;
                $display("FAIL win_timeout: no winner id=%0d by cycle %0d", w.id, w.due);
            end
            if (clm_q.size() > 0 && cyc > clm_q[0].due) begin
                cl = clm_q.pop_front();
                checks++;
                failures++;
                $display("FAIL claim_timeout: no claim id=%0d by cycle %0d", cl.id, cl.due);
            end
            if (vld === 1'b1 && (pv !== 1'b1 || id !== pid || key !== pkey || ohv !== phv)) begin
                checks++;
                if (win_q.size() == 0) begin
                    failures++;
                    $display("FAIL win_unexpected: got id=%0d key=%0d hv=%0d at cycle %0d, expected none",
                             id, key, ohv, cyc);
                end else begin
                    w = win_q.pop_front();
                    if (id !== w.id || key !== w.key || ohv !== w.hv || cyc != w.due) begin
                        failures++;
                        $display("FAIL win: got id=%0d key=%0d hv=%0d cycle=%0d expected id=%0d key=%0d hv=%0d cycle=%0d",
                                 id, key, ohv, cyc, w.id, w.key, w.hv, w.due);
                    end
                end
            end
            if (cvld === 1'b1) begin
                checks++;
                if (clm_q.size() == 0) begin
                    failures++;
                    $display("FAIL claim_unexpected: got claim id=%0d at cycle %0d, expected none", cid, cyc);
                end else begin
                    cl = clm_q.pop_front();
                    if (cid !== cl.id || cyc != cl.due || vld !== 1'b0) begin
                        failures++;
                        $display("FAIL claim: got id=%0d cycle=%0d vld=%0d expected id=%0d cycle=%0d vld=0",
                                 cid, cyc, vld, cl.id, cl.due);
                    end
                end
            end
        end
        pv   = vld;
        pid  = id;
        pkey = key;
        phv  = ohv;
        if (done) begin
            while (win_q.size() > 0) begin
                w = win_q.pop_front();
                checks++;
                failures++;
                $display("FAIL win_missing: got nothing expected id=%0d at cycle %0d", w.id, w.due);
            end
            while (clm_q.size() > 0) begin
                cl = clm_q.pop_front();
                checks++;
                failures++;
                $display("FAIL claim_missing: got nothing expected id=%0d at cycle %0d", cl.id, cl.due);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of run, expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
